load_align_unit: RTL and testbench

- Sequential, parametrised successor to the combinational load data-extension stage; sits between the M stage and the data-memory read port.
- Accepts one load request at a time and issues the word-aligned bus reads.
- Extracts and sign- or zero-extends byte/half/word data, then returns the result over a valid/ready handshake.
- Supports flush (exception/interrupt) abort, including abort with a read still in flight.

---
 rtl/load_align_pkg.sv | 33 +++
 rtl/load_extract.sv | 35 +++
 rtl/load_align_unit.sv | 150 +++++++++++++++
 tb/tb_load_align_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_align_pkg.sv
// Shared definitions for the load alignment unit: load op codes, FSM states
// and small sizing helpers.
package load_align_pkg;

    localparam logic [2:0] OP_LW  = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;
    localparam logic [2:0] OP_LB  = 3'd5;
    localparam logic [2:0] OP_LHU = 3'd6;
    localparam logic [2:0] OP_LBU = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RESP,
        ST_DRAIN
    } state_t;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Access size in bytes; 0 for the no-load ops.
    function automatic logic [3:0] op_bytes(input logic [2:0] op);
        case (op)
            OP_LW:          return 4'd4;
            OP_LH, OP_LHU:  return 4'd2;
            OP_LB, OP_LBU:  return 4'd1;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension. Operates on a two-word
// window so the same logic serves single-beat reads and merged split reads.
module load_extract
    import load_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [2*DATA_W-1:0] i_word,
    input  logic [OFF_W-1:0]    i_offset,
    input  logic [2:0]          i_op,
    output logic [DATA_W-1:0]   o_data
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = '0;
        // Offset never exceeds LANES-1, so the 4-byte window stays inside i_word.
        for (int k = 0; k < 4; k++) begin
            w_raw[8*k +: 8] = i_word[(int'(i_offset) + k)*8 +: 8];
        end

        o_data = '0;
        case (i_op)
            OP_LW:   o_data = DATA_W'($signed(w_raw));
            OP_LH:   o_data = DATA_W'($signed(w_raw[15:0]));
            OP_LB:   o_data = DATA_W'($signed(w_raw[7:0]));
            OP_LHU:  o_data = DATA_W'(w_raw[15:0]);
            OP_LBU:  o_data = DATA_W'(w_raw[7:0]);
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: bus-word reads, lane extraction, valid/ready result, flush abort.
// Define MISALIGN_SPLIT_EN to service misaligned loads (two reads when crossing a bus word).
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int LANES = byte_lanes(DATA_W);
    localparam int OFF_W = $clog2(LANES);

    state_t              r_state;
    state_t              w_state_next;
    logic [OFF_W-1:0]    r_offset;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;
    logic [2*DATA_W-1:0] w_word;
    logic [DATA_W-1:0]   w_ext;
    logic                w_accept;
    logic                w_is_load;
    logic                w_mis_err;
    logic                w_cross;
    logic                w_beat_done;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && !flush;
    assign w_is_load   = (req_op >= OP_LW);
    assign w_beat_done = mem_ack && !flush && (r_state == ST_RD0 || r_state == ST_RD1);

`ifdef MISALIGN_SPLIT_EN
    logic [DATA_W-1:0] r_low;

    assign w_mis_err = 1'b0;
    assign w_cross   = (int'(r_offset) + int'(op_bytes(r_op))) > LANES;
    assign w_word    = (r_state == ST_RD1) ? {mem_rdata, r_low} : {{DATA_W{1'b0}}, mem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low <= '0;
        end else if (w_beat_done && r_state == ST_RD0 && w_cross) begin
            r_low <= mem_rdata;
        end
    end
`else
    assign w_mis_err = (req_op == OP_LW && req_addr[1:0] != 2'b00) ||
                       ((req_op == OP_LH || req_op == OP_LHU) && req_addr[0]);
    assign w_cross   = 1'b0;
    assign w_word    = {{DATA_W{1'b0}}, mem_rdata};
`endif

    load_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .i_word   (w_word),
        .i_offset (r_offset),
        .i_op     (r_op),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = (!w_is_load || w_mis_err) ? ST_RESP : ST_RD0;
                end
            end
            ST_RD0, ST_RD1: begin
                mem_req = 1'b1;
                // A flush with the ack in hand can finish at once; otherwise the read must drain.
                if (flush) begin
                    w_state_next = mem_ack ? ST_IDLE : ST_DRAIN;
                end else if (mem_ack) begin
                    w_state_next = (r_state == ST_RD0 && w_cross) ? ST_RD1 : ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (flush || rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset   <= '0;
            r_op       <= '0;
            r_mem_addr <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_offset   <= req_addr[OFF_W-1:0];
            r_op       <= req_op;
            r_mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_data     <= '0;
            r_err      <= w_is_load && w_mis_err;
        end else if (w_beat_done) begin
            if (r_state == ST_RD0 && w_cross) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(LANES);
            end else begin
                r_data <= w_ext;
            end
        end
    end

    assign mem_addr = mem_req ? r_mem_addr : '0;
    assign rsp_data = r_data;
    assign rsp_err  = r_err;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit (DATA_W=32) with a delayed-ack memory responder.
// Expectations follow MISALIGN_SPLIT_EN when the bench is built with it.
module tb_load_align_unit;
    import load_align_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [2:0]        req_op = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    always #5 clk = ~clk;

    load_align_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: explicit words where a test needs them, a hash elsewhere.
    logic [31:0] mem_map [logic [31:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem_map.exists(a)) return mem_map[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference result {err, data} built byte by byte from the memory model.
    function automatic logic [32:0] model(input logic [31:0] addr, input logic [2:0] op);
        int          size;
        logic [31:0] v;
        size = (op == OP_LW) ? 4 : (op == OP_LH || op == OP_LHU) ? 2 :
               (op == OP_LB || op == OP_LBU) ? 1 : 0;
        if (size == 0) return 33'd0;
`ifndef MISALIGN_SPLIT_EN
        if ((size == 4 && addr[1:0] != 2'b00) || (size == 2 && addr[0])) return {1'b1, 32'd0};
`endif
        v = '0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = byte_at(addr + 32'(k));
        if (op == OP_LB && v[7])  v[31:8]  = '1;
        if (op == OP_LH && v[15]) v[31:16] = '1;
        return {1'b0, v};
    endfunction

    logic [32:0] exp_q [$];
    logic [31:0] rd_addrs [$];
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          n_memreq = 0;
    int          ack_cyc = 0;
    int          cyc = 0;
    bit          rsp_seen = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder and bus monitor, evaluated on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mem_ack  = 1'b0;
            ack_cnt  = 0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_req && !mem_req) check_eq("mem_req_dropped_after_ack", prev_ack, 1);
            if (rsp_valid) rsp_seen = 1'b1;
            if (mem_req) n_memreq++;
            prev_req = mem_req;
            if (mem_ack) begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end else if (mem_req) begin
                if (ack_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word_at(mem_addr);
                    rd_addrs.push_back(mem_addr);
                    ack_cyc   = cyc;
                    ack_cnt   = 0;
                end else begin
                    ack_cnt++;
                end
            end
            prev_ack = mem_ack;
        end
    end

    // One request through to handshake; exp_lat > 0 also checks acceptance-to-rsp_valid cycles.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input int dly,
                           input int hold, input int exp_lat);
        logic [32:0] exp;
        logic [31:0] held;
        int          lat;
        ack_delay = dly;
        req_addr  = addr;
        req_op    = op;
        req_valid = 1'b1;
        exp_q.push_back(model(addr, op));
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", rsp_valid, 1);
            void'(exp_q.pop_front());
            return;
        end
        if (exp_lat > 0) check_eq("latency", lat, exp_lat);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_data", rsp_data, held);
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        $display("load op=%0d addr=0x%08h -> data=0x%08h err=%0d (lat %0d, hold %0d)",
                 op, addr, rsp_data, rsp_err, lat, hold);
        check_eq($sformatf("rsp op%0d @%08h", op, addr), {rsp_err, rsp_data}, exp);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_released", rsp_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_mem_req", mem_req, 0);
        check_eq("reset_mem_addr", mem_addr, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_data", rsp_data, 0);
        check_eq("reset_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem_map[32'h1000] = 32'h80FF_1234;
        mem_map[32'h2000] = 32'h9ABC_0000;
        mem_map[32'h3000] = 32'h4433_2211;
        mem_map[32'h3004] = 32'h8877_6655;

        do_load(32'h1003, OP_LB, 0, 0, 2);
        do_load(32'h2002, OP_LHU, 0, 0, 2);
        do_load(32'h2002, OP_LH, 1, 0, 3);

        n_memreq = 0;
        rd_addrs.delete();
`ifdef MISALIGN_SPLIT_EN
        do_load(32'h3001, OP_LW, 0, 0, 0);
        check_eq("split_reads", rd_addrs.size(), 2);
        if (rd_addrs.size() == 2) begin
            check_eq("split_addr_lo", rd_addrs[0], 32'h3000);
            check_eq("split_addr_hi", rd_addrs[1], 32'h3004);
        end
`else
        do_load(32'h3001, OP_LW, 0, 0, 1);
        check_eq("misaligned_no_bus", n_memreq, 0);
`endif
        do_load(32'h3002, OP_LHU, 0, 0, 0);
        do_load(32'h5000, 3'd0, 0, 0, 1);
        do_load(32'h1001, OP_LBU, 2, 5, 0);

        for (int i = 0; i < 24; i++) begin
            do_load(32'h4000 + 32'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end

        // Flush in RD0 with a slow ack: read must drain, no response.
        ack_delay = 3;
        rsp_seen  = 1'b0;
        req_addr  = 32'h1000;
        req_op    = OP_LW;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("flush_rd0_mem_req", mem_req, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_to_idle", req_ready, 1);
        check_eq("drain_ready_cycle", cyc, ack_cyc + 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("drain_no_rsp", rsp_seen, 0);
        $display("flush in RD0 with delayed ack: drained");

        // Flush coinciding with the ack: straight back to idle.
        ack_delay = 0;
        rsp_seen  = 1'b0;
        req_addr  = 32'h1000;
        req_op    = OP_LW;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_ack_idle", req_ready, 1);
        check_eq("flush_ack_no_req", mem_req, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("flush_ack_no_rsp", rsp_seen, 0);
        $display("flush with ack in same cycle: discarded");

        // Flush while the response is waiting: response dropped.
        req_addr  = 32'h1000;
        req_op    = OP_LBU;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check_eq("resp_reached", rsp_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_resp_drop", rsp_valid, 0);
        check_eq("flush_resp_idle", req_ready, 1);
        $display("flush in RESP: response dropped");

        // Flush in IDLE blocks acceptance.
        flush     = 1'b1;
        req_addr  = 32'h1000;
        req_op    = OP_LW;
        req_valid = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check_eq("flush_idle_blocks", mem_req, 0);
        check_eq("flush_idle_ready", req_ready, 1);
        $display("flush in IDLE: request blocked");

        do_load(32'h2002, OP_LH, 0, 0, 2);

        // Asynchronous reset in the middle of a read.
        ack_delay = 10;
        req_addr  = 32'h1000;
        req_op    = OP_LW;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rst_mid_mem_req_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_mem_req", mem_req, 0);
        check_eq("rst_mid_req_ready", req_ready, 1);
        check_eq("rst_mid_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_after_idle", req_ready, 1);
        $display("reset mid-RD0: read abandoned");

        do_load(32'h1003, OP_LB, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
